// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MEM-stage data-memory sequencer for the pipelined MIPS core. It accepts one
//   load/store from decode, talks to a word-wide single-port synchronous RAM,
//   extracts and extends byte/halfword load lanes, and performs sub-word
//   stores as read-modify-write. Upstream is held through stall until the
//   access reaches its response cycle.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req                     memory instruction present in MEM
//   we                      1 = store, 0 = load
//   rd_mask / wr_mask       access size: 1111 word, 0011 half, 0001 byte
//   unsgn                   zero-extend sub-word loads when 1
//   addr, wdata             byte address and store data (sub-word in low bits)
//   rdata, done, misalign   registered response, valid while done = 1
//   stall                   combinational pipeline hold
//   ram_addr/we/wdata/rdata synchronous RAM port (read data one cycle later)
module mem_access_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [3:0]        rd_mask,
    input  logic [3:0]        wr_mask,
    input  logic              unsgn,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              misalign,
    output logic              stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESP
    } state_t;

    localparam logic [3:0] MASK_WORD = 4'b1111;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_BYTE = 4'b0001;

    state_t state_q, state_d;

    // Request fields captured at acceptance
    logic        we_q, we_d;
    logic [3:0]  mask_q, mask_d;
    logic        unsgn_q, unsgn_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;

    // Registered outputs
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              misalign_q, misalign_d;

    logic [3:0] act_mask;

    // Address bits above the RAM window do not take part in the access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    // Invalid size encodings are reported the same way as misalignment.
    function automatic logic bad_request(input logic [3:0] m, input logic [1:0] a);
        case (m)
            MASK_WORD: bad_request = (a != 2'b00);
            MASK_HALF: bad_request = a[0];
            MASK_BYTE: bad_request = 1'b0;
            default:   bad_request = 1'b1;
        endcase
    endfunction

    // Little-endian lane pick followed by sign or zero extension.
    function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                 input logic [3:0]  m,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        if (m == MASK_WORD) begin
            extract_lane = word;
        end else if (m == MASK_HALF) begin
            extract_lane = {{16{~uns & h[15]}}, h};
        end else begin
            extract_lane = {{24{~uns & b[7]}}, b};
        end
    endfunction

    // Replace only the addressed lane; all other bytes keep the RAM value.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [15:0] wd,
                                               input logic [3:0]  m,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        if (m == MASK_HALF) begin
            if (off[1]) r[31:16] = wd;
            else        r[15:0]  = wd;
        end else begin
            case (off)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end
        merge_lane = r;
    endfunction

    assign act_mask = we ? wr_mask : rd_mask;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        mask_d      = mask_q;
        unsgn_d     = unsgn_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        misalign_d  = misalign_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d       = we;
                    mask_d     = act_mask;
                    unsgn_d    = unsgn;
                    off_d      = addr[1:0];
                    wdata_d    = wdata[15:0];
                    ram_addr_d = addr[ADDR_W+1:2];
                    rdata_d    = 32'd0;
                    if (bad_request(act_mask, addr[1:0])) begin
                        // Response goes out directly; the RAM is never touched.
                        misalign_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = RESP;
                    end else begin
                        misalign_d = 1'b0;
                        if (we && act_mask == MASK_WORD) begin
                            ram_wdata_d = wdata;
                            ram_we_d    = 1'b1;
                            state_d     = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (we_q) begin
                    ram_wdata_d = merge_lane(ram_rdata, wdata_q, mask_q, off_q);
                    ram_we_d    = 1'b1;
                    state_d     = WRITE;
                end else begin
                    rdata_d = extract_lane(ram_rdata, mask_q, off_q, unsgn_q);
                    done_d  = 1'b1;
                    state_d = RESP;
                end
            end
            WRITE: begin
                done_d  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
        end
    end

    // Request fields are always re-captured before use, so they need no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        mask_q  <= mask_d;
        unsgn_q <= unsgn_d;
        off_q   <= off_d;
        wdata_q <= wdata_d;
    end

    assign stall     = req & (state_q != RESP);
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign misalign  = misalign_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

endmodule
